// File: rtl/booth_controller_if.sv
// booth_controller_if
//   Bundles the handshake and datapath control/status signals of the Booth
//   multiplier controller.
//   Requester/datapath side (master) drives:
//     start, abort, counter_zero, booth_bits
//   Controller side (slave) drives:
//     load_registers, load_counter, add_operation, sub_operation,
//     shift_enable, decrement_counter, busy, done, state
interface booth_controller_if;
  logic       start;
  logic       abort;
  logic       counter_zero;
  logic [1:0] booth_bits;
  logic       load_registers;
  logic       load_counter;
  logic       add_operation;
  logic       sub_operation;
  logic       shift_enable;
  logic       decrement_counter;
  logic       busy;
  logic       done;
  logic [1:0] state;

  modport master (
    output start, abort, counter_zero, booth_bits,
    input  load_registers, load_counter, add_operation, sub_operation,
           shift_enable, decrement_counter, busy, done, state
  );

  modport slave (
    input  start, abort, counter_zero, booth_bits,
    output load_registers, load_counter, add_operation, sub_operation,
           shift_enable, decrement_counter, busy, done, state
  );
endinterface

// File: rtl/booth_controller.sv
// booth_controller
//   Control FSM for the 8-bit sequential Booth multiplier datapath.
//   Sequence: IDLE -> LOAD -> EXEC (8 operative cycles + 1 terminal cycle)
//   -> DONE -> IDLE. Start-to-done latency is 11 cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - booth_controller_if.slave: start/abort request, datapath status
//          (counter_zero, booth_bits) in; datapath strobes, busy, done and
//          debug state out.
module booth_controller (
  input  logic                clk,
  input  logic                rst,
  booth_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: state_d = EXEC;
      EXEC: if (bus.counter_zero) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Strobe decode. Outputs are functions of the registered state, qualified
  // by abort and by the datapath status; nothing here is registered on its
  // own, so the datapath sees the strobes in the same cycle as the state.
  logic load_registers;
  logic load_counter;
  logic add_operation;
  logic sub_operation;
  logic shift_enable;
  logic decrement_counter;
  logic done;
  logic exec_active;

  // An operative EXEC cycle: counter not yet exhausted.
  assign exec_active = (state_q == EXEC) && !bus.counter_zero;

  always_comb begin
    load_registers    = 1'b0;
    load_counter      = 1'b0;
    add_operation     = 1'b0;
    sub_operation     = 1'b0;
    shift_enable      = 1'b0;
    decrement_counter = 1'b0;
    done              = 1'b0;
    if (!bus.abort) begin
      if (state_q == LOAD) begin
        load_registers = 1'b1;
        load_counter   = 1'b1;
      end
      if (exec_active) begin
        shift_enable      = 1'b1;
        decrement_counter = 1'b1;
        // {Q[0], q_minus_1}: 10 starts a run of ones (subtract),
        // 01 ends one (add); 00/11 are shift-only.
        sub_operation = (bus.booth_bits == 2'b10);
        add_operation = (bus.booth_bits == 2'b01);
      end
      done = (state_q == DONE);
    end
  end

  assign bus.load_registers    = load_registers;
  assign bus.load_counter      = load_counter;
  assign bus.add_operation     = add_operation;
  assign bus.sub_operation     = sub_operation;
  assign bus.shift_enable      = shift_enable;
  assign bus.decrement_counter = decrement_counter;
  assign bus.done              = done;
  assign bus.busy              = (state_q == LOAD) || (state_q == EXEC);
  assign bus.state             = state_q;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller
//   Drives booth_controller through a small behavioural Booth datapath and
//   compares timing, strobe sequences and products against values derived
//   from plain signed arithmetic and the bit-pair recoding rule.
module tb_booth_controller;

  logic clk;
  logic rst;
  booth_controller_if bus ();

  booth_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural datapath: reacts to the controller's strobes.
  // ---------------------------------------------------------------------
  logic [7:0] op_mcand;
  logic [7:0] op_mult;
  logic [7:0] dp_a;
  logic [7:0] dp_q;
  logic [7:0] dp_m;
  logic       dp_qm1;
  logic [3:0] dp_cnt;
  logic [7:0] next_a;

  always_comb begin
    next_a = dp_a;
    if (bus.add_operation)      next_a = dp_a + dp_m;
    else if (bus.sub_operation) next_a = dp_a - dp_m;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_qm1 <= 1'b0; dp_cnt <= '0;
    end else begin
      if (bus.load_registers) begin
        dp_a <= '0; dp_q <= op_mult; dp_m <= op_mcand; dp_qm1 <= 1'b0;
      end
      if (bus.shift_enable) {dp_a, dp_q, dp_qm1} <= {next_a[7], next_a, dp_q};
      if (bus.load_counter)           dp_cnt <= 4'd8;
      else if (bus.decrement_counter) dp_cnt <= dp_cnt - 4'd1;
    end
  end

  assign bus.counter_zero = (dp_cnt == 4'd0);
  assign bus.booth_bits   = {dp_q[0], dp_qm1};

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {load_registers, load_counter, add, sub, shift, dec, busy, done}
  function automatic logic [7:0] outs();
    return {bus.load_registers, bus.load_counter, bus.add_operation,
            bus.sub_operation, bus.shift_enable, bus.decrement_counter,
            bus.busy, bus.done};
  endfunction

  // Expected op per iteration from the multiplier bit pairs {m[i], m[i-1]},
  // m[-1] = 0. Two bits per step: 2'b10 = sub, 2'b01 = add, 2'b00 = none.
  function automatic logic [15:0] ref_ops(input logic [7:0] mp);
    logic [15:0] ops;
    logic        prev;
    ops  = '0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mp[i] && !prev)      ops[2*i +: 2] = 2'b10;
      else if (!mp[i] && prev) ops[2*i +: 2] = 2'b01;
      prev = mp[i];
    end
    return ops;
  endfunction

  function automatic logic [15:0] ref_product(input logic [7:0] mc, input logic [7:0] mp);
    int p;
    p = int'($signed(mc)) * int'($signed(mp));
    return p[15:0];
  endfunction

  // One full multiplication. Observation k happens in cycle T+k, where T is
  // the cycle in which start is sampled. With poke set, start is pulsed
  // during EXEC and DONE and must be ignored.
  task automatic do_mult(input logic [7:0] mc, input logic [7:0] mp,
                         input bit poke, input string tag);
    int busy_n, shift_n, dec_n, done_n, done_at, both_n, ld_sh_n, exec_i;
    logic [15:0] ops_obs;
    logic [15:0] prod_obs;
    busy_n = 0; shift_n = 0; dec_n = 0; done_n = 0; done_at = -1;
    both_n = 0; ld_sh_n = 0; exec_i = 0; ops_obs = '0; prod_obs = '0;
    @(negedge clk);
    check({tag, "_pre_state"}, 32'(bus.state), 32'd0);
    op_mcand  = mc;
    op_mult   = mp;
    bus.start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 4 || k == 11);
      if (bus.busy) busy_n++;
      if (bus.decrement_counter) dec_n++;
      if (bus.add_operation && bus.sub_operation) both_n++;
      if (bus.load_registers && bus.shift_enable) ld_sh_n++;
      if (bus.shift_enable) begin
        shift_n++;
        if (exec_i < 8) ops_obs[2*exec_i +: 2] = {bus.sub_operation, bus.add_operation};
        exec_i++;
      end
      if (bus.done) begin
        done_n++;
        done_at  = k;
        prod_obs = {dp_a, dp_q};
      end
      if (k >= 12) check({tag, "_idle_after"}, 32'(bus.state), 32'd0);
    end
    bus.start = 1'b0;
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_done_latency"}, 32'(done_at), 32'd11);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
    check({tag, "_shift_cycles"}, 32'(shift_n), 32'd8);
    check({tag, "_dec_cycles"}, 32'(dec_n), 32'd8);
    check({tag, "_op_sequence"}, 32'(ops_obs), 32'(ref_ops(mp)));
    check({tag, "_product"}, 32'(prod_obs), 32'(ref_product(mc, mp)));
    check({tag, "_add_and_sub"}, 32'(both_n), 32'd0);
    check({tag, "_load_and_shift"}, 32'(ld_sh_n), 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int load_n, done_n, first_load, second_load;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    op_mcand  = '0;
    op_mult   = '0;
    rst       = 1'b1;
    #12;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_mult(8'd7, 8'd3, 1'b0, "m7x3");
    do_mult(8'd5, 8'hFD, 1'b0, "m5xm3");
    do_mult(8'd11, 8'h55, 1'b0, "m11x55");
    do_mult(8'd9, 8'h00, 1'b0, "m9x00");
    do_mult(8'd9, 8'hFF, 1'b0, "m9xFF");
    do_mult(8'd127, 8'h80, 1'b0, "m127x80");
    do_mult(8'h81, 8'h7F, 1'b1, "poke");

    // start held high: accepts every 12 cycles.
    load_n = 0; done_n = 0; first_load = -1; second_load = -1;
    @(negedge clk);
    op_mcand  = 8'd3;
    op_mult   = 8'd4;
    bus.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.load_registers) begin
        load_n++;
        if (first_load < 0) first_load = k;
        else if (second_load < 0) second_load = k;
      end
      if (bus.done) done_n++;
    end
    bus.start = 1'b0;
    check("hold_first_load", 32'(first_load), 32'd1);
    check("hold_period", 32'(second_load - first_load), 32'd12);
    check("hold_loads", 32'(load_n), 32'd3);
    check("hold_dones", 32'(done_n), 32'd2);
    repeat (15) @(negedge clk);
    check("hold_drained", 32'(bus.state), 32'd0);

    // abort at T+5.
    op_mcand  = 8'd7;
    op_mult   = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check("abort_strobes_forced", 32'(outs() & 8'hFD), 32'd0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_outputs", 32'(outs()), 32'd0);
    done_n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);

    // async reset at T+6, mid-cycle.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_mult(8'd7, 8'd3, 1'b0, "after_rst");

    // Randomized operands; multiplicand limited to -127..127.
    for (int n = 0; n < 20; n++) begin
      int mc;
      mc = int'($urandom_range(254)) - 127;
      do_mult(8'(mc), 8'($urandom), ($urandom_range(1) == 1), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
